// File: rtl/rom_fetch_seq.sv
// Burst address sequencer for an async-read ROM, with a 2-entry valid/ready output buffer.
// Optional ROM_CHECKSUM_EN adds a per-burst mod-256 checksum of the transferred bytes.
module rom_fetch_seq #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LW    = 2;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] remaining;
    logic [DW-1:0] tail_data;
    logic          tail_last;
    logic          tail_valid;

    logic [LW-1:0] level;
    logic          full;
    logic          pop;
    logic          push;
    logic          push_last;

    // Head entry drives the outputs directly; tail entry absorbs one word of backpressure.
    assign level     = LW'(out_valid) + LW'(tail_valid);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = (state == FETCH) && (!full || pop);
    assign push_last = (remaining == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            remaining  <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            tail_data  <= '0;
            tail_last  <= 1'b0;
            tail_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done <= 1'b0;

            // Head refill: older tail word first, otherwise the word arriving this cycle.
            if (pop || !out_valid) begin
                if (tail_valid) begin
                    out_data  <= tail_data;
                    out_last  <= tail_last;
                    out_valid <= 1'b1;
                end else if (push) begin
                    out_data  <= rom_data;
                    out_last  <= push_last;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            if (tail_valid && pop) begin
                tail_valid <= push;
                if (push) begin
                    tail_data <= rom_data;
                    tail_last <= push_last;
                end
            end else if (!tail_valid && push && out_valid && !pop) begin
                tail_valid <= 1'b1;
                tail_data  <= rom_data;
                tail_last  <= push_last;
            end

`ifdef ROM_CHECKSUM_EN
            if (pop) begin
                checksum <= checksum + out_data;
            end
`endif

            unique case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr  <= base_addr;
                        remaining <= (len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, len};
                        busy      <= 1'b1;
                        state     <= FETCH;
`ifdef ROM_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (push) begin
                        rom_addr  <= rom_addr + AW'(1);
                        remaining <= remaining - CW'(1);
                        if (push_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Randomized scoreboard bench for rom_fetch_seq: expected words queued at start, checked by a monitor.
module tb_rom_fetch_seq;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } word_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef ROM_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] rom [256];
    word_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         ready_mode = 0;
    int         ready_ph = 0;

    rom_fetch_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer readiness: 0 = always ready, 1 = random, 2 = repeating 1,0,0.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = ((ready_ph % 3) == 0);
                default: out_ready = 1'b1;
            endcase
            ready_ph++;
        end
    end

    // Monitor: pops the reference stream on each transfer and checks hold, done and checksum rules.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic       done_exp = 1'b0;
    logic [7:0] sum = '0;
    logic [7:0] final_sum = '0;
    word_t      w;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
            sum        = '0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            chk("done_pulse", 32'(done), 32'(done_exp));
            done_exp = 1'b0;
            if (done) begin
                chk("busy_at_done", 32'(busy), 32'd0);
`ifdef ROM_CHECKSUM_EN
                chk("checksum_done", 32'(checksum), 32'(final_sum));
`endif
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected no transfer", out_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("data", 32'(out_data), 32'(w.data));
                    chk("last", 32'(out_last), 32'(w.last));
`ifdef ROM_CHECKSUM_EN
                    chk("checksum_run", 32'(checksum), 32'(sum));
`endif
                    sum = sum + out_data;
                    if (w.last) begin
                        done_exp  = 1'b1;
                        final_sum = sum;
                        sum       = '0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Issue a start at the current negedge (DUT idle) and queue the words the burst must produce.
    task automatic issue(input logic [7:0] b, input logic [7:0] l);
        int    n;
        word_t e;
        n = (l == 8'd0) ? 256 : int'(l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        for (int i = 0; i < n; i++) begin
            e.data = rom[8'(int'(b) + i)];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            k++;
            if (k > 3000) begin
                checks++;
                errors++;
                $display("FAIL wait_done: got no done pulse expected one within 3000 cycles");
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h40] = 8'h01;
        rom[8'h41] = 8'h02;
        rom[8'h42] = 8'hFF;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic burst with first-word latency and done timing.
        issue(8'h00, 8'd4);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle2_data", 32'(out_data), 32'(rom[0]));
        wait_done();
        chk("done_cycle", 32'(cyc - start_cyc), 32'd5);

        // Backpressure with a 1,0,0 ready pattern.
        ready_mode = 2;
        @(negedge clk);
        issue(8'h10, 8'd5);
        wait_done();

        // Address wrap, then a full 256-word burst.
        ready_mode = 1;
        @(negedge clk);
        issue(8'hFE, 8'd4);
        wait_done();
        ready_mode = 0;
        issue(8'h00, 8'd0);
        wait_done();

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        issue(8'h20, 8'd6);
        @(negedge clk);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h80;
        len       = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        issue(8'h50, 8'd3);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done();

        // Checksum burst over 0x01, 0x02, 0xFF.
        ready_mode = 1;
        @(negedge clk);
        issue(8'h40, 8'd3);
        wait_done();
`ifdef ROM_CHECKSUM_EN
        chk("checksum_fixed", 32'(checksum), 32'h02);
`endif

        // Reset mid-burst aborts with no done pulse; next burst runs normally.
        ready_mode = 2;
        @(negedge clk);
        issue(8'h30, 8'd20);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst1");
        @(negedge clk);
        chk_reset_outputs("midrst2");
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(8'h33, 8'd7);
        wait_done();

        // Random bursts with random consumer behaviour.
        for (int r = 0; r < 15; r++) begin
            ready_mode = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(8'($urandom), 8'($urandom_range(1, 12)));
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
